// File: rtl/paralelo_serial_crc.sv
`default_nettype none
// ============================================================================
//  Module   : paralelo_serial_crc
//  Purpose  : Parallel-to-serial converter for the SD CMD line with an
//             optional on-the-fly CRC7 and end bit.
//  Revision : 1.0 - initial release
// ============================================================================
module paralelo_serial_crc #(
    parameter int WIDTH      = 40,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit CRC_EN     = 1'b1,
    parameter bit IDLE_LEVEL = 1'b1
) (
    input  logic             sd_clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] parallel,
    output logic             serial,
    output logic             busy,
    output logic             complete
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] C_LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] C_LAST_CRC = CNT_W'(6);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_CRC   = 2'd2,
        ST_ENDB  = 2'd3
    } state_t;

    state_t             r_state, w_state_n;
    logic               r_serial, w_serial_n;
    logic               r_busy, w_busy_n;
    logic               r_complete, w_complete_n;
    logic [WIDTH-1:0]   r_shift, w_shift_n;
    logic [CNT_W-1:0]   r_cnt, w_cnt_n;
    logic [6:0]         r_crc, w_crc_n;

    logic               w_load_bit;
    logic [WIDTH-1:0]   w_load_rest;
    logic               w_next_bit;
    logic [WIDTH-1:0]   w_next_rest;
    logic [2:0]         w_crc_idx;

    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic bit_in);
        logic fb;
        fb = bit_in ^ crc[6];
        return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    // The shift register always presents the next payload bit at one fixed end.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_load_bit  = parallel[WIDTH-1];
            assign w_load_rest = {parallel[WIDTH-2:0], 1'b0};
            assign w_next_bit  = r_shift[WIDTH-1];
            assign w_next_rest = {r_shift[WIDTH-2:0], 1'b0};
        end else begin : g_lsb_first
            assign w_load_bit  = parallel[0];
            assign w_load_rest = {1'b0, parallel[WIDTH-1:1]};
            assign w_next_bit  = r_shift[0];
            assign w_next_rest = {1'b0, r_shift[WIDTH-1:1]};
        end
    endgenerate

    assign w_crc_idx = 3'd5 - r_cnt[2:0];

    always_ff @(posedge sd_clock or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_serial   <= IDLE_LEVEL;
            r_busy     <= 1'b0;
            r_complete <= 1'b0;
            r_shift    <= '0;
            r_cnt      <= '0;
            r_crc      <= '0;
        end else begin
            r_state    <= w_state_n;
            r_serial   <= w_serial_n;
            r_busy     <= w_busy_n;
            r_complete <= w_complete_n;
            r_shift    <= w_shift_n;
            r_cnt      <= w_cnt_n;
            r_crc      <= w_crc_n;
        end
    end

    always_comb begin
        w_state_n    = r_state;
        w_serial_n   = r_serial;
        w_busy_n     = r_busy;
        w_complete_n = 1'b0;
        w_shift_n    = r_shift;
        w_cnt_n      = r_cnt;
        w_crc_n      = r_crc;

        case (r_state)
            ST_IDLE: begin
                w_serial_n = IDLE_LEVEL;
                w_busy_n   = 1'b0;
                if (enable) begin
                    // CRC covers each bit as it is placed on the line, starting from 0.
                    w_shift_n  = w_load_rest;
                    w_cnt_n    = '0;
                    w_crc_n    = crc7_step(7'd0, w_load_bit);
                    w_serial_n = w_load_bit;
                    w_busy_n   = 1'b1;
                    w_state_n  = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (r_cnt == C_LAST_BIT) begin
                    if (CRC_EN) begin
                        w_state_n  = ST_CRC;
                        w_cnt_n    = '0;
                        w_serial_n = r_crc[6];
                    end else begin
                        w_state_n    = ST_IDLE;
                        w_serial_n   = IDLE_LEVEL;
                        w_busy_n     = 1'b0;
                        w_complete_n = 1'b1;
                    end
                end else begin
                    w_serial_n = w_next_bit;
                    w_shift_n  = w_next_rest;
                    w_crc_n    = crc7_step(r_crc, w_next_bit);
                    w_cnt_n    = r_cnt + CNT_W'(1);
                end
            end
            ST_CRC: begin
                if (r_cnt == C_LAST_CRC) begin
                    w_state_n  = ST_ENDB;
                    w_serial_n = 1'b1;
                end else begin
                    w_serial_n = r_crc[w_crc_idx];
                    w_cnt_n    = r_cnt + CNT_W'(1);
                end
            end
            ST_ENDB: begin
                w_state_n    = ST_IDLE;
                w_serial_n   = IDLE_LEVEL;
                w_busy_n     = 1'b0;
                w_complete_n = 1'b1;
            end
            default: begin
                w_state_n  = ST_IDLE;
                w_serial_n = IDLE_LEVEL;
                w_busy_n   = 1'b0;
            end
        endcase
    end

    assign serial   = r_serial;
    assign busy     = r_busy;
    assign complete = r_complete;

endmodule
`default_nettype wire

// File: tb/tb_paralelo_serial_crc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_paralelo_serial_crc
//  Purpose  : Directed self-checking bench for paralelo_serial_crc.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_paralelo_serial_crc;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [39:0] parallel;
    logic        serial, busy, complete;

    logic        en8;
    logic [7:0]  par8;
    logic        ser8, busy8, cmp8;

    int errors = 0;
    int checks = 0;

    localparam logic [47:0] C_CMD0 = {40'h40_0000_0000, 8'h95};
    localparam logic [47:0] C_CMD8 = {40'h48_0000_01AA, 8'h87};
    localparam logic [7:0]  C_SEQ8 = 8'b1000_1101;

    always #5 clk = ~clk;

    paralelo_serial_crc dut (
        .sd_clock (clk),
        .reset    (reset),
        .enable   (enable),
        .parallel (parallel),
        .serial   (serial),
        .busy     (busy),
        .complete (complete)
    );

    paralelo_serial_crc #(
        .WIDTH      (8),
        .MSB_FIRST  (1'b0),
        .CRC_EN     (1'b0),
        .IDLE_LEVEL (1'b1)
    ) dut8 (
        .sd_clock (clk),
        .reset    (reset),
        .enable   (en8),
        .parallel (par8),
        .serial   (ser8),
        .busy     (busy8),
        .complete (cmp8)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " serial"}, 64'(serial), 64'd1);
        chk({tag, " busy"}, 64'(busy), 64'd0);
        chk({tag, " complete"}, 64'(complete), 64'd0);
    endtask

    // Enable must already be high ahead of the accepting edge.
    task automatic check_frame(input string tag, input logic [47:0] exp, input bit drop_en,
                               input logic [39:0] next_par, input int glitch_at);
        for (int i = 0; i < 48; i++) begin
            @(negedge clk);
            chk($sformatf("%s bit%0d", tag, i), 64'(serial), 64'(exp[47-i]));
            chk($sformatf("%s busy%0d", tag, i), 64'(busy), 64'd1);
            chk($sformatf("%s cmp%0d", tag, i), 64'(complete), 64'd0);
            if (i == 0) begin
                parallel = next_par;
                if (drop_en) enable = 1'b0;
            end
            if (i == glitch_at) begin
                enable   = 1'b1;
                parallel = 40'hFF_FFFF_FFFF;
            end else if (i == glitch_at + 1) begin
                enable   = 1'b0;
                parallel = 40'h0;
            end
        end
        @(negedge clk);
        chk({tag, " end serial"}, 64'(serial), 64'd1);
        chk({tag, " end busy"}, 64'(busy), 64'd0);
        chk({tag, " end complete"}, 64'(complete), 64'd1);
    endtask

    initial begin
        reset    = 1'b0;
        enable   = 1'b0;
        parallel = 40'h40_0000_0000;
        en8      = 1'b0;
        par8     = 8'hFF;

        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk_idle($sformatf("reset%0d", i));
            chk($sformatf("reset%0d ser8", i), 64'(ser8), 64'd1);
            chk($sformatf("reset%0d cmp8", i), 64'(cmp8), 64'd0);
            enable = ~enable;
            en8    = ~en8;
        end
        enable = 1'b0;
        en8    = 1'b0;
        reset  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_idle($sformatf("post_reset%0d", i));
        end

        // CMD0 single frame
        parallel = 40'h40_0000_0000;
        enable   = 1'b1;
        check_frame("cmd0", C_CMD0, 1'b1, 40'h0, -10);
        @(negedge clk);
        chk_idle("cmd0 after");

        // CMD8 with an ignored mid-frame enable pulse
        parallel = 40'h48_0000_01AA;
        enable   = 1'b1;
        check_frame("cmd8", C_CMD8, 1'b1, 40'h0, 10);
        @(negedge clk);
        chk_idle("cmd8 after");

        // 8-bit LSB-first instance, no CRC
        par8 = 8'b1011_0001;
        en8  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("w8 bit%0d", i), 64'(ser8), 64'(C_SEQ8[7-i]));
            chk($sformatf("w8 busy%0d", i), 64'(busy8), 64'd1);
            chk($sformatf("w8 cmp%0d", i), 64'(cmp8), 64'd0);
            en8 = 1'b0;
        end
        @(negedge clk);
        chk("w8 end serial", 64'(ser8), 64'd1);
        chk("w8 end busy", 64'(busy8), 64'd0);
        chk("w8 end complete", 64'(cmp8), 64'd1);
        @(negedge clk);
        chk("w8 after complete", 64'(cmp8), 64'd0);

        // Back-to-back frames with enable held high
        parallel = 40'h40_0000_0000;
        enable   = 1'b1;
        check_frame("b2b0", C_CMD0, 1'b0, 40'h48_0000_01AA, -10);
        check_frame("b2b1", C_CMD8, 1'b1, 40'h0, -10);
        @(negedge clk);
        chk_idle("b2b after");

        // Reset asserted at bit 20 of CMD0
        parallel = 40'h40_0000_0000;
        enable   = 1'b1;
        for (int i = 0; i <= 20; i++) begin
            @(negedge clk);
            enable = 1'b0;
        end
        chk("abort bit20", 64'(serial), 64'(C_CMD0[27]));
        chk("abort busy pre", 64'(busy), 64'd1);
        #2 reset = 1'b0;
        #1;
        chk_idle("abort now");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_idle($sformatf("abort hold%0d", i));
        end
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_idle($sformatf("abort rel%0d", i));
        end
        parallel = 40'h40_0000_0000;
        enable   = 1'b1;
        check_frame("cmd0 again", C_CMD0, 1'b1, 40'h0, -10);
        @(negedge clk);
        chk_idle("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
